// File: rtl/cmd_seq_pkg.sv
// Shared opcodes, state encoding and command decode helpers for cmd_sequencer.
package cmd_seq_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned MAX_CH = 32;

  localparam logic [OP_W-1:0] OP_LOAD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_CONV  = 4'b0001;
  localparam logic [OP_W-1:0] OP_WRITE = 4'b0010;
  localparam logic [OP_W-1:0] OP_PRINT = 4'b0100;
  localparam logic [OP_W-1:0] OP_END   = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  // Which enable groups an opcode drives on its masked channels.
  typedef struct packed {
    logic rom;
    logic conv;
    logic ram;
    logic we;
  } en_sel_t;

  // END is legal with any mask; other phases need at least one channel.
  function automatic logic op_legal(input logic [OP_W-1:0] op,
                                    input logic [MAX_CH-1:0] mask);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD, OP_CONV, OP_WRITE, OP_PRINT: ok = (mask != '0);
      OP_END:                               ok = 1'b1;
      default:                              ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic en_sel_t op_enables(input logic [OP_W-1:0] op);
    en_sel_t s;
    s = '0;
    case (op)
      OP_LOAD:  s.rom = 1'b1;
      OP_CONV:  begin s.rom = 1'b1; s.conv = 1'b1; end
      OP_WRITE: begin s.rom = 1'b1; s.conv = 1'b1; s.ram = 1'b1; s.we = 1'b1; end
      OP_PRINT: s.ram = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cmd_sequencer_phase_counter.sv
// Down-counter holding the remaining active cycles of the current phase.
module phase_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero_c
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/cmd_sequencer.sv
// N-channel command sequencer: accepts opcode+mask commands and holds
// per-channel enables for a programmed number of cycles.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned LOAD_CYCLES  = 16,
  parameter int unsigned CONV_CYCLES  = 64,
  parameter int unsigned WRITE_CYCLES = 16,
  parameter int unsigned PRINT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic [OP_W+NUM_CH-1:0] cmd,
  output logic                   cmd_ready,
  output logic [NUM_CH-1:0]      rom_en,
  output logic [NUM_CH-1:0]      ram_en,
  output logic [NUM_CH-1:0]      ram_we,
  output logic [NUM_CH-1:0]      conv_en,
  output logic [NUM_CH-1:0]      finish,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   halted
);

  localparam int unsigned CMD_W = OP_W + NUM_CH;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;

  logic [OP_W-1:0]     cmd_op;
  logic [NUM_CH-1:0]   cmd_mask;
  logic                accept;

  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]    cnt_load_val, cnt_val;

  logic                run_c, last_c;
  en_sel_t             sel;

  logic                ready_d, busy_d, done_d, err_d, halted_d;
  logic [NUM_CH-1:0]   rom_d, ram_d, we_d, conv_d, finish_d;

  assign cmd_op   = cmd[CMD_W-1:NUM_CH];
  assign cmd_mask = cmd[NUM_CH-1:0];
  assign accept   = cmd_valid && cmd_ready;

  // Counter preload is the phase length minus one.
  always_comb begin
    cnt_load_val = '0;
    case (cmd_op)
      OP_LOAD:  cnt_load_val = CNT_W'(LOAD_CYCLES - 1);
      OP_CONV:  cnt_load_val = CNT_W'(CONV_CYCLES - 1);
      OP_WRITE: cnt_load_val = CNT_W'(WRITE_CYCLES - 1);
      OP_PRINT: cnt_load_val = CNT_W'(PRINT_CYCLES - 1);
      default:  cnt_load_val = '0;
    endcase
  end

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .count    (cnt_val),
    .zero_c   (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
    end
  end

  // Next state plus next output values; outputs are registered below so
  // the first active cycle starts right after the accepting edge.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mask_d   = mask_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    run_c    = 1'b0;
    last_c   = 1'b0;
    sel      = '0;
    ready_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    halted_d = 1'b0;
    rom_d    = '0;
    ram_d    = '0;
    we_d     = '0;
    conv_d   = '0;
    finish_d = '0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d = 1'b0;
          if (cmd_op == OP_END) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else if (op_legal(cmd_op, MAX_CH'(cmd_mask))) begin
            state_d  = S_RUN;
            op_d     = cmd_op;
            mask_d   = cmd_mask;
            cnt_load = 1'b1;
            run_c    = 1'b1;
            last_c   = (cnt_load_val == '0);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          run_c   = 1'b1;
          last_c  = (cnt_val == CNT_W'(1));
        end
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (run_c) begin
      sel    = op_enables(op_d);
      busy_d = 1'b1;
      done_d = last_c;
      rom_d  = sel.rom  ? mask_d : '0;
      conv_d = sel.conv ? mask_d : '0;
      ram_d  = sel.ram  ? mask_d : '0;
      we_d   = sel.we   ? mask_d : '0;
      finish_d = (op_d == OP_PRINT && last_c) ? mask_d : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      halted    <= 1'b0;
      rom_en    <= '0;
      ram_en    <= '0;
      ram_we    <= '0;
      conv_en   <= '0;
      finish    <= '0;
    end else begin
      cmd_ready <= ready_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      halted    <= halted_d;
      rom_en    <= rom_d;
      ram_en    <= ram_d;
      ram_we    <= we_d;
      conv_en   <= conv_d;
      finish    <= finish_d;
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer (4 channels, short phase lengths).
module tb_cmd_sequencer;
  import cmd_seq_pkg::*;

  localparam int unsigned NCH = 4;

  logic           clk;
  logic           rst_n;
  logic           cmd_valid;
  logic [7:0]     cmd;
  logic           cmd_ready, busy, done, err, halted;
  logic [NCH-1:0] rom_en, ram_en, ram_we, conv_en, finish;
  logic [24:0]    obs;

  int n_chk  = 0;
  int n_fail = 0;

  cmd_sequencer #(
    .NUM_CH       (NCH),
    .CNT_W        (8),
    .LOAD_CYCLES  (3),
    .CONV_CYCLES  (5),
    .WRITE_CYCLES (16),
    .PRINT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .rom_en    (rom_en),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .conv_en   (conv_en),
    .finish    (finish),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {cmd_ready, busy, done, err, halted, rom_en, ram_en, ram_we, conv_en, finish};

  function automatic logic [24:0] ev(input logic rdy, input logic bsy, input logic dn,
                                     input logic er, input logic hl,
                                     input logic [3:0] rom, input logic [3:0] ram,
                                     input logic [3:0] we, input logic [3:0] cv,
                                     input logic [3:0] fin);
    return {rdy, bsy, dn, er, hl, rom, ram, we, cv, fin};
  endfunction

  task automatic chk(input string tag, input logic [24:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a command for one accepting edge, then drop valid.
  task automatic issue(input logic [3:0] op, input logic [3:0] mask);
    cmd_valid = 1'b1;
    cmd       = {op, mask};
    step();
    cmd_valid = 1'b0;
  endtask

  localparam logic [24:0] IDLE_V = 25'h1000000;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = '0;
    step();
    step();
    chk("reset_all_zero", '0);
    rst_n = 1'b1;
    #1 chk("ready_low_before_edge", '0);
    step();
    chk("ready_after_release", IDLE_V);

    // LOAD on channels 0 and 2
    issue(OP_LOAD, 4'b0101);
    chk("load_c1", ev(0, 1, 0, 0, 0, 4'b0101, 0, 0, 0, 0));
    step();
    chk("load_c2", ev(0, 1, 0, 0, 0, 4'b0101, 0, 0, 0, 0));
    step();
    chk("load_c3_done", ev(0, 1, 1, 0, 0, 4'b0101, 0, 0, 0, 0));
    step();
    chk("load_idle", IDLE_V);

    // WRITE then CONV held valid: one idle bubble between them
    cmd_valid = 1'b1;
    cmd       = {OP_WRITE, 4'b1111};
    step();
    cmd = {OP_CONV, 4'b0010};
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("write_c%0d", i + 1),
          ev(0, 1, (i == 15), 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 0));
      step();
    end
    chk("bubble", IDLE_V);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("conv_c%0d", i + 1),
          ev(0, 1, (i == 4), 0, 0, 4'b0010, 0, 0, 4'b0010, 0));
      step();
    end
    chk("conv_idle", IDLE_V);

    // PRINT on channel 3
    issue(OP_PRINT, 4'b1000);
    chk("print_c1", ev(0, 1, 0, 0, 0, 0, 4'b1000, 0, 0, 0));
    step();
    chk("print_c2_finish", ev(0, 1, 1, 0, 0, 0, 4'b1000, 0, 0, 4'b1000));
    step();
    chk("print_idle", IDLE_V);

    // Illegal opcode and zero mask
    issue(4'b0011, 4'b0001);
    chk("bad_op_err", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step();
    chk("bad_op_recover", IDLE_V);
    issue(OP_LOAD, 4'b0000);
    chk("zero_mask_err", ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step();
    chk("zero_mask_recover", IDLE_V);

    // Reset in the 3rd CONV cycle
    issue(OP_CONV, 4'b0001);
    chk("conv2_c1", ev(0, 1, 0, 0, 0, 4'b0001, 0, 0, 4'b0001, 0));
    step();
    step();
    chk("conv2_c3", ev(0, 1, 0, 0, 0, 4'b0001, 0, 0, 4'b0001, 0));
    #1 rst_n = 1'b0;
    #1 chk("midphase_reset_clear", '0);
    step();
    chk("reset_held_no_done", '0);
    rst_n = 1'b1;
    step();
    chk("ready_after_midphase_reset", IDLE_V);

    // END, then a LOAD that must be ignored
    issue(OP_END, 4'b0000);
    chk("end_halted", ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    issue(OP_LOAD, 4'b0001);
    chk("halt_ignore_load", ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step();
    chk("halt_sticky", ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    #1 chk("halt_reset_clear", '0);
    step();
    rst_n = 1'b1;
    step();
    chk("ready_after_halt_reset", IDLE_V);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
